// File: rtl/company_name_streamer.sv
// company_name_streamer: on a start pulse, streams the five company names
// (Intel, AMD, APPLE, LENOVO, HP) as ASCII bytes over a valid/ready handshake.
// SEP_CHAR follows every name and is flagged with out_last.
// All outputs come straight from registers.
module company_name_streamer #(
    parameter logic [7:0] SEP_CHAR = 8'h0A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic [2:0] name_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [2:0] char_cnt, char_cnt_n, char_inc;
    logic [2:0] name_idx_n, name_inc;
    logic [7:0] data_n;
    logic       valid_n, last_n, busy_n, done_n;

    // Number of characters in each name.
    function automatic logic [2:0] name_len(input logic [2:0] n);
        case (n)
            3'd0:    name_len = 3'd5;
            3'd1:    name_len = 3'd3;
            3'd2:    name_len = 3'd5;
            3'd3:    name_len = 3'd6;
            3'd4:    name_len = 3'd2;
            default: name_len = 3'd1;
        endcase
    endfunction

    // Character ROM, addressed by {name index, character index}.
    function automatic logic [7:0] rom_char(input logic [2:0] n, input logic [2:0] c);
        case ({n, c})
            6'o00: rom_char = 8'h49; // I
            6'o01: rom_char = 8'h6E; // n
            6'o02: rom_char = 8'h74; // t
            6'o03: rom_char = 8'h65; // e
            6'o04: rom_char = 8'h6C; // l
            6'o10: rom_char = 8'h41; // A
            6'o11: rom_char = 8'h4D; // M
            6'o12: rom_char = 8'h44; // D
            6'o20: rom_char = 8'h41; // A
            6'o21: rom_char = 8'h50; // P
            6'o22: rom_char = 8'h50; // P
            6'o23: rom_char = 8'h4C; // L
            6'o24: rom_char = 8'h45; // E
            6'o30: rom_char = 8'h4C; // L
            6'o31: rom_char = 8'h45; // E
            6'o32: rom_char = 8'h4E; // N
            6'o33: rom_char = 8'h4F; // O
            6'o34: rom_char = 8'h56; // V
            6'o35: rom_char = 8'h4F; // O
            6'o40: rom_char = 8'h48; // H
            6'o41: rom_char = 8'h50; // P
            default: rom_char = 8'h00;
        endcase
    endfunction

    // Next state and next registered outputs; the byte presented next cycle is
    // computed here so the outputs can be driven directly from flops.
    always_comb begin
        state_n    = state;
        char_cnt_n = char_cnt;
        name_idx_n = name_idx;
        data_n     = out_data;
        valid_n    = out_valid;
        last_n     = out_last;
        busy_n     = busy;
        done_n     = 1'b0;
        char_inc   = char_cnt + 3'd1;
        name_inc   = name_idx + 3'd1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SEND;
                    char_cnt_n = '0;
                    name_idx_n = '0;
                    data_n     = rom_char(3'd0, 3'd0);
                    valid_n    = 1'b1;
                    last_n     = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        char_cnt_n = '0;
                        if (name_idx == 3'd4) begin
                            state_n = FIN;
                            valid_n = 1'b0;
                            last_n  = 1'b0;
                            data_n  = '0;
                            done_n  = 1'b1;
                        end else begin
                            name_idx_n = name_inc;
                            data_n     = rom_char(name_inc, 3'd0);
                            last_n     = 1'b0;
                        end
                    end else begin
                        char_cnt_n = char_inc;
                        if (char_inc == name_len(name_idx)) begin
                            data_n = SEP_CHAR;
                            last_n = 1'b1;
                        end else begin
                            data_n = rom_char(name_idx, char_inc);
                        end
                    end
                end
            end
            FIN: begin
                state_n    = IDLE;
                busy_n     = 1'b0;
                name_idx_n = '0;
                char_cnt_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            char_cnt  <= '0;
            name_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            char_cnt  <= char_cnt_n;
            name_idx  <= name_idx_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_company_name_streamer.sv
// Bench for company_name_streamer: table-driven full-speed sequence plus
// hand-written back-pressure, ignored-start and mid-sequence reset cases.
// A second instance with SEP_CHAR=8'h2C runs in lockstep on the same inputs.
module tb_company_name_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data, d2_data;
    logic       out_valid, out_last, busy, done;
    logic       d2_valid, d2_last, d2_busy, d2_done;
    logic [2:0] name_idx, d2_idx;

    company_name_streamer dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .name_idx(name_idx), .busy(busy), .done(done)
    );

    company_name_streamer #(.SEP_CHAR(8'h2C)) dut2 (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .out_data(d2_data), .out_valid(d2_valid), .out_last(d2_last),
        .name_idx(d2_idx), .busy(d2_busy), .done(d2_done)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic       rst, start, rdy;
        logic       valid;
        logic [7:0] data;
        logic [7:0] data2;
        logic       last;
        logic [2:0] idx;
        logic       busy, done;
        logic       chk_data;
    } vec_t;

    vec_t       tbl[$];
    string      names[5];
    logic [7:0] exp_b[26];
    logic [7:0] exp_b2[26];
    logic       exp_l[26];
    logic [2:0] exp_i[26];

    function automatic vec_t mk(input logic r, s, rd, v, input logic [7:0] d, d2,
                                input logic l, input logic [2:0] ix,
                                input logic b, dn, cd);
        vec_t t;
        t.rst = r; t.start = s; t.rdy = rd; t.valid = v; t.data = d; t.data2 = d2;
        t.last = l; t.idx = ix; t.busy = b; t.done = dn; t.chk_data = cd;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sequence under a back-pressure pattern; mode 0 toggles ready,
    // mode 1 randomises it. With pulses set, start is also raised at beats 3
    // and 20 and during the done cycle.
    task automatic run_stream(input int mode, input bit pulses);
        int k = 0;
        int dones = 0;
        int cyc;
        bit stall = 0;
        bit p3 = 0, p20 = 0;
        logic [7:0] hd;
        logic       hl;
        logic [2:0] hi;
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) begin
            if (stall)
                check("stall_hold", {out_valid, out_last, name_idx, out_data}, {1'b1, hl, hi, hd});
            if (!busy) break;
            out_ready = (mode == 0) ? cyc[0] : 1'($urandom_range(0, 1));
            start = 1'b0;
            if (pulses) begin
                if (k == 3 && !p3) begin start = 1'b1; p3 = 1; end
                if (k == 20 && !p20) begin start = 1'b1; p20 = 1; end
                if (done) start = 1'b1;
            end
            if (done) dones++;
            if (out_valid && out_ready) begin
                if (k < 26) begin
                    check("bp_data", out_data, exp_b[k]);
                    check("bp_last", out_last, exp_l[k]);
                    check("bp_idx", name_idx, exp_i[k]);
                    check("bp_data_sep2c", d2_data, exp_b2[k]);
                end
                k++;
            end
            stall = out_valid && !out_ready;
            hd = out_data; hl = out_last; hi = name_idx;
            step();
        end
        start = 1'b0;
        check("bp_timeout", cyc < 300, 1);
        check("bp_beats", k, 26);
        check("bp_done_pulses", dones, 1);
        check("bp_idle_state", {out_valid, busy, name_idx}, 5'b0);
        if (pulses) begin
            // Start in the first IDLE cycle after FIN must be taken.
            start = 1'b1;
            step();
            start = 1'b0;
            check("restart_after_fin", {out_valid, busy, out_data}, {2'b11, 8'h49});
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
    endtask

    initial begin
        int k;
        names[0] = "Intel"; names[1] = "AMD"; names[2] = "APPLE";
        names[3] = "LENOVO"; names[4] = "HP";
        k = 0;
        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < names[n].len(); j++) begin
                exp_b[k] = names[n][j]; exp_b2[k] = names[n][j];
                exp_l[k] = 1'b0; exp_i[k] = 3'(n); k++;
            end
            exp_b[k] = 8'h0A; exp_b2[k] = 8'h2C; exp_l[k] = 1'b1; exp_i[k] = 3'(n); k++;
        end

        // Reset with start high (reset wins), one idle cycle, then start.
        tbl.push_back(mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, exp_b[0], exp_b2[0], exp_l[0], exp_i[0], 1, 0, 1));
        for (int b = 1; b < 26; b++)
            tbl.push_back(mk(0, 0, 1, 1, exp_b[b], exp_b2[b], exp_l[b], exp_i[b], 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 4, 1, 1, 0)); // FIN
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0)); // IDLE
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; out_ready = tbl[i].rdy;
            step();
            check("valid", out_valid, tbl[i].valid);
            check("last", out_last, tbl[i].last);
            check("name_idx", name_idx, tbl[i].idx);
            check("busy", busy, tbl[i].busy);
            check("done", done, tbl[i].done);
            if (tbl[i].chk_data) begin
                check("data", out_data, tbl[i].data);
                check("data_sep2c", d2_data, tbl[i].data2);
                check("last_sep2c", d2_last, tbl[i].last);
            end
        end
        start = 1'b0;

        run_stream(0, 0);
        run_stream(1, 0);
        run_stream(1, 1);

        // Reset in the middle of LENOVO, then restart from 'I'.
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 40 && name_idx != 3'd3; c++) step();
        check("reach_lenovo", name_idx, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_seq", {out_valid, out_last, busy, done, name_idx}, 7'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_after_rst", {out_valid, busy, name_idx, out_data}, {2'b11, 3'd0, 8'h49});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/company_name_streamer.md
# company_name_streamer

Synthesizable source stage that feeds the name-printing stage. On a start pulse it emits five product company names (Intel, AMD, APPLE, LENOVO, HP) as an ASCII byte stream, one character per accepted beat, under a valid/ready handshake. A configurable separator byte follows each name. The consumer prints or forwards the stream.

## Interface
Parameters:
- SEP_CHAR, 8'h0A — separator byte emitted after the last character of every name.

Ports:
- clk  input  1  — single clock; all logic on posedge clk.
- rst  input  1  — synchronous, active-high reset.
- start  input  1  — begin one full sequence; sampled only in IDLE.
- out_ready  input  1  — consumer can accept a beat this cycle.
- out_data  output  8  — current ASCII byte.
- out_valid  output  1  — out_data is valid.
- out_last  output  1  — current beat is a separator (end of a name).
- name_idx  output  3  — index of the name being sent: 0=Intel, 1=AMD, 2=APPLE, 3=LENOVO, 4=HP.
- busy  output  1  — sequence in progress.
- done  output  1  — one-cycle pulse after the final beat is accepted.

## Operation
- Internal constant ROM holds the names, uppercase/lowercase exactly as listed.
- Name lengths are 5, 3, 5, 6, 2 (21 chars). With 5 separators, a sequence is 26 beats.
- FSM states and transitions:
  - IDLE → SEND on start.
  - SEND → SEND while beats remain.
  - SEND → FIN when the HP separator is accepted.
  - FIN → IDLE unconditionally after 1 cycle.
- Counters:
  - char_cnt (3 bits) indexes within a name; name_idx (3 bits) selects the name.
  - On acceptance of a non-separator beat, char_cnt increments.
  - After the last character of a name, the next beat is SEP_CHAR with out_last=1.
  - On acceptance of the separator, char_cnt clears and name_idx increments.
  - name_idx never exceeds 4; it returns to 0 on entering IDLE.
- Handshake rules:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_last and name_idx hold stable.
  - out_valid never drops until its beat transfers.
- Start and busy:
  - start is ignored in SEND and FIN, with no queuing.
  - busy = 1 in SEND and FIN.
- done:
  - Asserted only in FIN, for exactly 1 cycle.
  - Simultaneous start during FIN is ignored. start in the following IDLE cycle is accepted.
- All outputs are registered.

## Timing
- Reset values: out_data=8'h00, out_valid=0, out_last=0, name_idx=0, busy=0, done=0; FSM=IDLE, char_cnt=0.
- Reset is synchronous. rst asserted mid-sequence forces the reset values at the next edge, abandoning the sequence, and rst has priority over start. The first post-reset start begins again at 'I'.
- Latency:
  - start sampled high in IDLE at edge N → out_valid=1 with out_data=8'h49 ('I') after edge N, and busy=1.
  - Each accepted beat presents the next byte in the following cycle (zero bubbles).
  - With out_ready held high, the 26 beats occupy 26 consecutive cycles, and done pulses in the cycle after the last beat.
- Start to done with continuous ready: 27 cycles. With back-pressure, the duration is 27 plus the number of stalled cycles.

## Test plan
- Reset, then start with out_ready=1:
  - Captured stream is "Intel",0A,"AMD",0A,"APPLE",0A,"LENOVO",0A,"HP",0A (26 bytes).
  - out_last=1 only on the five 0A beats.
  - done high for exactly 1 cycle, 27 cycles after start.
- Toggle out_ready every cycle, then random back-pressure:
  - Same 26-byte stream, with no drops or duplicates.
  - out_data is stable across every stall cycle.
- Pulse start again at beats 3 and 20 and during FIN:
  - Sequence is unaffected, and exactly one done pulse occurs.
- Assert rst during LENOVO (name_idx=3) for 1 cycle:
  - Next cycle: out_valid=0, busy=0, name_idx=0.
  - Restart yields 'I' first.
- Parameter override SEP_CHAR=8'h2C:
  - Separators are 8'h2C, and total beat count is unchanged at 26.
- Name index check:
  - name_idx reads 0,1,2,3,4 on the first character of each respective name.
  - name_idx returns to 0 once the FSM is back in IDLE.
